holy_gpio_irq: RTL and testbench
================================

// Module: holy_gpio_irq
// PURPOSE
//   AXI-Lite GPIO peripheral that generates interrupts. It drives the pins selected as outputs
//   and synchronizes the pin inputs. Per-pin edge or level events are latched in a W1C status
//   register. irq_o is one wire and drives one irq_in line of the PLIC (upstream interrupt source).
// PARAMETERS
//   NUM_PINS   8             GPIO pin count, 1..32; register bits >= NUM_PINS read 0, writes ignored
//   BASE_ADDR  32'h0000_0000 base of the 32-byte register window; decode uses (addr - BASE_ADDR)
// PORTS
//   clk            in   1         single clock
//   rst_n          in   1         reset, synchronous, active-low
//   gpio_in        in   NUM_PINS  async pin inputs
//   gpio_out       out  NUM_PINS  = DATA_OUT register
//   gpio_oe        out  NUM_PINS  = DIR register (1 = drive pin)
//   s_axi_aw*/w*/b*/ar*/r*  AXI-Lite slave: awaddr[31:0] awvalid awready wdata[31:0] wstrb[3:0]
//                  wvalid wready bresp[1:0] bvalid bready araddr[31:0] arvalid arready
//                  rdata[31:0] rresp[1:0] rvalid rready
//   irq_o          out  1         registered, |(IRQ_STATUS & IRQ_EN)
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): all registers, synchronizers and FSMs clear to 0.
//     awready=wready=arready=0 during reset, 1 in the first idle cycle after reset.
//     bvalid=rvalid=0, bresp=rresp=0, rdata=0, irq_o=0, gpio_out=gpio_oe=0.
//     Reset mid-transaction abandons it; no response is issued.
//   Register map (offset = addr-BASE_ADDR, index = offset[4:2], offset[1:0] ignored):
//     0x00 DATA_IN RO   synchronized pins     0x04 DATA_OUT RW     0x08 DIR RW
//     0x0C IRQ_EN RW    0x10 IRQ_TYPE RW (0 level, 1 edge)
//     0x14 IRQ_POL RW (0 high/rising, 1 low/falling)
//     0x18 IRQ_STATUS W1C
//     0x1C unmapped; offset >= 0x20 or addr < BASE_ADDR is unmapped -> resp SLVERR (2'b10),
//       rdata=0, no write effect. Mapped access -> OKAY (2'b00). Writes to DATA_IN have no effect
//       and return OKAY.
//   Write FSM W_IDLE/W_RESP:
//     W_IDLE: awready=wready=1; a write is accepted only in a cycle where awvalid && wvalid.
//       The register is updated at that edge; go to W_RESP.
//     W_RESP: awready=wready=0, bvalid=1 and bresp are held until bready; then W_IDLE.
//     Write data is byte-masked by wstrb for both RW and W1C registers.
//   Read FSM R_IDLE/R_DATA:
//     R_IDLE: arready=1; on arvalid, rdata/rresp are captured and the FSM goes to R_DATA.
//     R_DATA: rvalid=1, rdata is stable until rready; arready=0.
//     Read latency is 1 cycle from the handshake to rvalid.
//     Read and write channels are independent. A read captured in the same cycle as a write
//     returns the pre-write value.
//   Input path: 2-flop sync (s1 -> s2), plus a delay flop s3 <= s2. DATA_IN = s2.
//     A pin change becomes visible in DATA_IN 2 edges after it is sampled.
//   Events per pin i:
//     edge:  rising = s2&~s3, falling = ~s2&s3, selected by POL.
//     level: s2 == ~POL.
//     IRQ_STATUS[i] sets at the edge where the event is true. Status sets regardless of IRQ_EN.
//     Clearing: W1C clears the bit. For a level-type pin whose level is still active, the bit
//       re-sets the same cycle, so it effectively stays 1.
//     Set and W1C in the same cycle: set wins (no event lost).
//   irq_o <= |(IRQ_STATUS & IRQ_EN & pin_mask), giving 1 cycle after status.
//     Pin edge -> irq_o latency: 4 edges.
//     Changing IRQ_TYPE/POL does not touch existing status bits.
// TESTING
//   T1 reset: hold rst_n=0 2 cycles -> all outputs 0; read 0x00..0x18 -> 0, rresp OKAY.
//   T2 RW: write DIR=0xFF, DATA_OUT=0xA5 (wstrb=4'hF) -> gpio_oe=0xFF, gpio_out=0xA5, bresp=0.
//      Then write 0x5A00_00FF with wstrb=4'h2 -> DATA_OUT unchanged (0xA5).
//   T3 edge IRQ: EN=0x01, TYPE=0x01, POL=0, drive gpio_in[0] 0->1.
//      -> STATUS=0x01 and irq_o=1, 4 edges later.
//      W1C 0x01 -> irq_o=0 two cycles after the write handshake.
//   T4 level IRQ: TYPE=0, POL=0x02, EN=0x02, gpio_in[1]=0 -> STATUS[1]=1.
//      W1C -> STATUS stays 1 while the pin is low.
//      Set pin high, then W1C -> STATUS=0, irq_o=0.
//   T5 collision: edge event on pin 0 in the same cycle as the W1C of bit 0 -> STATUS[0]=1.
//   T6 protocol: awvalid without wvalid for 5 cycles -> no accept.
//      Read 0x1C and 0x40 -> rresp=2'b10, rdata=0.
//      Hold rready=0 for 3 cycles -> rvalid/rdata stable.
//      Assert rst_n=0 during W_RESP -> bvalid=0 at the next edge.

Source files
------------

// File: rtl/holy_gpio_irq.sv
// AXI-Lite GPIO block: output/direction registers, synchronized inputs and
// per-pin edge/level interrupt events latched into a W1C status register.
module holy_gpio_irq #(
  parameter int unsigned NUM_PINS  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_PINS-1:0] gpio_in,
  output logic [NUM_PINS-1:0] gpio_out,
  output logic [NUM_PINS-1:0] gpio_oe,
  input  logic [31:0]         s_axi_awaddr,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [31:0]         s_axi_wdata,
  input  logic [3:0]          s_axi_wstrb,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [31:0]         s_axi_araddr,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [31:0]         s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  output logic                irq_o
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic {WIdle, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  // Offsets 0x00..0x18 are mapped; 0x1C and anything outside the window are not.
  function automatic logic addr_mapped(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && (off < 32'd32) && (off[4:2] != 3'd7);
  endfunction

  function automatic logic [2:0] addr_index(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return off[4:2];
  endfunction

  logic [NUM_PINS-1:0] sync1_q, sync2_q, sync3_q;
  logic [NUM_PINS-1:0] data_out_q, data_out_d;
  logic [NUM_PINS-1:0] dir_q, dir_d;
  logic [NUM_PINS-1:0] irq_en_q, irq_en_d;
  logic [NUM_PINS-1:0] irq_type_q, irq_type_d;
  logic [NUM_PINS-1:0] irq_pol_q, irq_pol_d;
  logic [NUM_PINS-1:0] irq_status_q, irq_status_d;
  logic [NUM_PINS-1:0] status_clr, pin_event;
  logic                irq_q;
  logic                ready_q;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;

  logic        w_fire, r_fire, w_mapped, r_mapped;
  logic [2:0]  w_idx, r_idx;
  logic [31:0] strb_mask, wr_bits;
  logic [NUM_PINS-1:0] wr_keep, wr_set, rd_pins;
  logic        unused_wr;

  // ready_q holds the channels off until the first cycle after reset is released
  assign s_axi_awready = ready_q && (w_state_q == WIdle);
  assign s_axi_wready  = s_axi_awready;
  assign s_axi_bvalid  = (w_state_q == WResp);
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = ready_q && (r_state_q == RIdle);
  assign s_axi_rvalid  = (r_state_q == RData);
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign gpio_out      = data_out_q;
  assign gpio_oe       = dir_q;
  assign irq_o         = irq_q;

  assign w_fire   = s_axi_awready && s_axi_awvalid && s_axi_wvalid;
  assign r_fire   = s_axi_arready && s_axi_arvalid;
  assign w_mapped = addr_mapped(s_axi_awaddr);
  assign r_mapped = addr_mapped(s_axi_araddr);
  assign w_idx    = addr_index(s_axi_awaddr);
  assign r_idx    = addr_index(s_axi_araddr);

  assign strb_mask = {{8{s_axi_wstrb[3]}}, {8{s_axi_wstrb[2]}},
                      {8{s_axi_wstrb[1]}}, {8{s_axi_wstrb[0]}}};
  assign wr_bits   = s_axi_wdata & strb_mask;
  assign wr_set    = wr_bits[NUM_PINS-1:0];
  assign wr_keep   = ~strb_mask[NUM_PINS-1:0];
  // Register bits above NUM_PINS are deliberately dropped
  assign unused_wr = ^{wr_bits, strb_mask};

  // Per-pin event: edge selects rising/falling by polarity, level compares against ~polarity
  always_comb begin
    logic [NUM_PINS-1:0] edge_evt, level_evt;
    edge_evt  = (sync2_q & ~sync3_q & ~irq_pol_q) | (~sync2_q & sync3_q & irq_pol_q);
    level_evt = sync2_q ^ irq_pol_q;
    pin_event = (irq_type_q & edge_evt) | (~irq_type_q & level_evt);
  end

  // Register-file next state; a new event overrides a simultaneous W1C
  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irq_en_d   = irq_en_q;
    irq_type_d = irq_type_q;
    irq_pol_d  = irq_pol_q;
    status_clr = '0;
    if (w_fire && w_mapped) begin
      case (w_idx)
        3'd1:    data_out_d = (data_out_q & wr_keep) | wr_set;
        3'd2:    dir_d      = (dir_q & wr_keep) | wr_set;
        3'd3:    irq_en_d   = (irq_en_q & wr_keep) | wr_set;
        3'd4:    irq_type_d = (irq_type_q & wr_keep) | wr_set;
        3'd5:    irq_pol_d  = (irq_pol_q & wr_keep) | wr_set;
        3'd6:    status_clr = wr_set;
        default: ;
      endcase
    end
    irq_status_d = (irq_status_q & ~status_clr) | pin_event;
  end

  // Write channel FSM: accept address and data together, then hold the response
  always_comb begin
    w_state_d = w_state_q;
    bresp_d   = bresp_q;
    unique case (w_state_q)
      WIdle: begin
        if (w_fire) begin
          w_state_d = WResp;
          bresp_d   = w_mapped ? RespOkay : RespSlverr;
        end
      end
      WResp: begin
        if (s_axi_bready) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  // Read data mux over pre-write register values
  always_comb begin
    rd_pins = '0;
    case (r_idx)
      3'd0:    rd_pins = sync2_q;
      3'd1:    rd_pins = data_out_q;
      3'd2:    rd_pins = dir_q;
      3'd3:    rd_pins = irq_en_q;
      3'd4:    rd_pins = irq_type_q;
      3'd5:    rd_pins = irq_pol_q;
      3'd6:    rd_pins = irq_status_q;
      default: rd_pins = '0;
    endcase
  end

  // Read channel FSM: capture on handshake, hold until rready
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      RIdle: begin
        if (r_fire) begin
          r_state_d = RData;
          rdata_d   = '0;
          if (r_mapped) begin
            rdata_d[NUM_PINS-1:0] = rd_pins;
            rresp_d = RespOkay;
          end else begin
            rresp_d = RespSlverr;
          end
        end
      end
      RData: begin
        if (s_axi_rready) r_state_d = RIdle;
      end
      default: r_state_d = RIdle;
    endcase
  end

  // Input synchronizer plus one delay stage for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Register file, status and registered interrupt output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out_q   <= '0;
      dir_q        <= '0;
      irq_en_q     <= '0;
      irq_type_q   <= '0;
      irq_pol_q    <= '0;
      irq_status_q <= '0;
      irq_q        <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      dir_q        <= dir_d;
      irq_en_q     <= irq_en_d;
      irq_type_q   <= irq_type_d;
      irq_pol_q    <= irq_pol_d;
      irq_status_q <= irq_status_d;
      irq_q        <= |(irq_status_q & irq_en_q);
    end
  end

  // Bus FSM state and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q   <= 1'b0;
      w_state_q <= WIdle;
      r_state_q <= RIdle;
      bresp_q   <= 2'b00;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
    end else begin
      ready_q   <= 1'b1;
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_holy_gpio_irq.sv
// Self-checking bench for holy_gpio_irq: directed scenarios plus a randomized
// run compared against a behavioural register/event model.
module tb_holy_gpio_irq;
  localparam int NP = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [NP-1:0] gpio_in, gpio_out, gpio_oe;
  logic [31:0]   s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
  logic [3:0]    s_axi_wstrb;
  logic          s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [1:0]    s_axi_bresp, s_axi_rresp;
  logic          s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic          s_axi_rvalid, s_axi_rready, irq_o;

  holy_gpio_irq #(.NUM_PINS(NP), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .irq_o(irq_o)
  );

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  logic [NP-1:0] m_out, m_dir, m_en, m_type, m_pol, m_status;
  logic [NP-1:0] h1, h2, h3;  // pin samples from the last three edges, newest first
  logic          m_irq, m_rdy, m_wbusy, m_rbusy;
  logic [1:0]    m_bresp, m_rresp;
  logic [31:0]   m_rdata;
  logic          last_aw_fire, last_ar_fire;

  // Advance one clock, updating the model from the inputs presented in this cycle
  task automatic tick();
    logic [NP-1:0] evt, clr;
    logic nirq;
    last_aw_fire = 1'b0;
    last_ar_fire = 1'b0;
    if (!rst_n) begin
      {m_out, m_dir, m_en, m_type, m_pol, m_status, h1, h2, h3} = '0;
      {m_irq, m_rdy, m_wbusy, m_rbusy} = '0;
      m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0;
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (m_type[i]) evt[i] = m_pol[i] ? (h3[i] && !h2[i]) : (!h3[i] && h2[i]);
        else           evt[i] = (h2[i] != m_pol[i]);
      end
      nirq = |(m_status & m_en);
      clr = '0;
      if (m_rdy && !m_rbusy && s_axi_arvalid) begin
        last_ar_fire = 1'b1;
        m_rbusy = 1'b1;
        m_rdata = '0;
        m_rresp = (s_axi_araddr < 32'd28) ? 2'b00 : 2'b10;
        case (s_axi_araddr / 32'd4)
          32'd0: m_rdata[NP-1:0] = h2;
          32'd1: m_rdata[NP-1:0] = m_out;
          32'd2: m_rdata[NP-1:0] = m_dir;
          32'd3: m_rdata[NP-1:0] = m_en;
          32'd4: m_rdata[NP-1:0] = m_type;
          32'd5: m_rdata[NP-1:0] = m_pol;
          32'd6: m_rdata[NP-1:0] = m_status;
          default: m_rdata = '0;
        endcase
      end else if (m_rbusy && s_axi_rready) begin
        m_rbusy = 1'b0;
      end
      if (m_rdy && !m_wbusy && s_axi_awvalid && s_axi_wvalid) begin
        last_aw_fire = 1'b1;
        m_wbusy = 1'b1;
        m_bresp = (s_axi_awaddr < 32'd28) ? 2'b00 : 2'b10;
        // With 8 pins only byte lane 0 carries register bits
        if (s_axi_wstrb[0]) begin
          case (s_axi_awaddr / 32'd4)
            32'd1: m_out  = s_axi_wdata[NP-1:0];
            32'd2: m_dir  = s_axi_wdata[NP-1:0];
            32'd3: m_en   = s_axi_wdata[NP-1:0];
            32'd4: m_type = s_axi_wdata[NP-1:0];
            32'd5: m_pol  = s_axi_wdata[NP-1:0];
            32'd6: clr    = s_axi_wdata[NP-1:0];
            default: ;
          endcase
        end
      end else if (m_wbusy && s_axi_bready) begin
        m_wbusy = 1'b0;
      end
      m_status = (m_status & ~clr) | evt;
      m_irq = nirq;
      h3 = h2; h2 = h1; h1 = gpio_in;
      m_rdy = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic bv);
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_aw_fire) break;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    if (!last_aw_fire) begin
      vectors++; miscompares++;
      $display("FAIL write_timeout addr=%h no handshake within 20 cycles", a);
    end
    resp = s_axi_bresp; bv = s_axi_bvalid;
    tick();
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output logic rv);
    s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_ar_fire) break;
    end
    s_axi_arvalid = 1'b0;
    if (!last_ar_fire) begin
      vectors++; miscompares++;
      $display("FAIL read_timeout addr=%h no handshake within 20 cycles", a);
    end
    d = s_axi_rdata; resp = s_axi_rresp; rv = s_axi_rvalid;
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; logic v;
    rst_n = 1'b0;
    tick(); tick();
    vectors++; if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b000) begin
      miscompares++; $display("FAIL reset_ready got=%b exp=000",
                              {s_axi_awready, s_axi_wready, s_axi_arready}); end
    vectors++; if ({s_axi_bvalid, s_axi_rvalid, irq_o} !== 3'b000) begin
      miscompares++; $display("FAIL reset_valid_irq got=%b exp=000",
                              {s_axi_bvalid, s_axi_rvalid, irq_o}); end
    vectors++; if ({gpio_out, gpio_oe} !== 16'h0) begin
      miscompares++; $display("FAIL reset_gpio got=%h exp=0000", {gpio_out, gpio_oe}); end
    vectors++; if ({s_axi_rdata, s_axi_rresp, s_axi_bresp} !== 36'h0) begin
      miscompares++; $display("FAIL reset_resp got=%h exp=0",
                              {s_axi_rdata, s_axi_rresp, s_axi_bresp}); end
    rst_n = 1'b1;
    tick();
    vectors++; if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
      miscompares++; $display("FAIL post_reset_ready got=%b exp=111",
                              {s_axi_awready, s_axi_wready, s_axi_arready}); end
    for (int k = 0; k < 7; k++) begin
      axi_read(32'(k * 4), d, r, v);
      vectors++; if (d !== 32'h0 || r !== 2'b00 || v !== 1'b1) begin
        miscompares++; $display("FAIL reset_read off=%0h got=%h/%b/%b exp=0/00/1", k * 4, d, r, v);
      end
    end
  endtask

  task automatic test_rw();
    logic [1:0] r; logic v; logic [31:0] d;
    axi_write(32'h08, 32'hFF, 4'hF, r, v);
    vectors++; if (r !== 2'b00 || v !== 1'b1) begin
      miscompares++; $display("FAIL rw_dir_bresp got=%b/%b exp=00/1", r, v); end
    axi_write(32'h04, 32'hA5, 4'hF, r, v);
    vectors++; if (gpio_oe !== 8'hFF) begin
      miscompares++; $display("FAIL rw_gpio_oe got=%h exp=ff", gpio_oe); end
    vectors++; if (gpio_out !== 8'hA5) begin
      miscompares++; $display("FAIL rw_gpio_out got=%h exp=a5", gpio_out); end
    axi_write(32'h04, 32'h5A00_00FF, 4'h2, r, v);
    vectors++; if (gpio_out !== 8'hA5 || r !== 2'b00) begin
      miscompares++; $display("FAIL rw_strb_mask got=%h/%b exp=a5/00", gpio_out, r); end
    axi_read(32'h04, d, r, v);
    vectors++; if (d !== 32'hA5) begin
      miscompares++; $display("FAIL rw_readback got=%h exp=000000a5", d); end
  endtask

  task automatic test_edge_irq();
    logic [1:0] r; logic v; logic [31:0] d;
    axi_write(32'h0C, 32'h01, 4'hF, r, v);
    axi_write(32'h10, 32'h01, 4'hF, r, v);
    axi_write(32'h14, 32'h00, 4'hF, r, v);
    gpio_in = 8'h01;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 3) begin
        vectors++; if (irq_o !== 1'b0) begin
          miscompares++; $display("FAIL edge_irq_early got=%b exp=0", irq_o); end
      end
    end
    vectors++; if (irq_o !== 1'b1) begin
      miscompares++; $display("FAIL edge_irq_latency got=%b exp=1", irq_o); end
    axi_read(32'h18, d, r, v);
    vectors++; if (d !== 32'h01) begin
      miscompares++; $display("FAIL edge_status got=%h exp=00000001", d); end
    axi_write(32'h18, 32'h01, 4'hF, r, v);
    vectors++; if (irq_o !== 1'b0) begin
      miscompares++; $display("FAIL edge_w1c_irq got=%b exp=0", irq_o); end
  endtask

  task automatic test_level_irq();
    logic [1:0] r; logic v; logic [31:0] d;
    gpio_in = 8'h00;
    repeat (4) tick();
    axi_write(32'h14, 32'h02, 4'hF, r, v);
    axi_write(32'h10, 32'h00, 4'hF, r, v);
    axi_write(32'h0C, 32'h02, 4'hF, r, v);
    axi_write(32'h18, 32'hFF, 4'hF, r, v);
    axi_read(32'h18, d, r, v);
    vectors++; if (d !== 32'h02) begin
      miscompares++; $display("FAIL level_status got=%h exp=00000002", d); end
    vectors++; if (irq_o !== 1'b1) begin
      miscompares++; $display("FAIL level_irq got=%b exp=1", irq_o); end
    axi_write(32'h18, 32'h02, 4'hF, r, v);
    axi_read(32'h18, d, r, v);
    vectors++; if (d !== 32'h02) begin
      miscompares++; $display("FAIL level_sticky got=%h exp=00000002", d); end
    gpio_in = 8'h02;
    repeat (4) tick();
    axi_write(32'h18, 32'h02, 4'hF, r, v);
    axi_read(32'h18, d, r, v);
    vectors++; if (d !== 32'h00) begin
      miscompares++; $display("FAIL level_cleared got=%h exp=00000000", d); end
    tick();
    vectors++; if (irq_o !== 1'b0) begin
      miscompares++; $display("FAIL level_irq_clear got=%b exp=0", irq_o); end
  endtask

  task automatic test_collision();
    logic [1:0] r; logic v; logic [31:0] d;
    axi_write(32'h10, 32'h03, 4'hF, r, v);
    axi_write(32'h14, 32'h00, 4'hF, r, v);
    axi_write(32'h0C, 32'h01, 4'hF, r, v);
    axi_write(32'h18, 32'hFF, 4'hF, r, v);
    gpio_in = 8'h03;
    tick(); tick();
    // Handshake lands on the edge where the rising event on pin 0 is seen
    axi_write(32'h18, 32'h01, 4'hF, r, v);
    axi_read(32'h18, d, r, v);
    vectors++; if (d !== 32'h01) begin
      miscompares++; $display("FAIL collision_status got=%h exp=00000001", d); end
    vectors++; if (d !== m_rdata) begin
      miscompares++; $display("FAIL collision_model got=%h exp=%h", d, m_rdata); end
  endtask

  task automatic test_protocol();
    logic [1:0] r; logic v; logic [31:0] d;
    s_axi_awaddr = 32'h04; s_axi_wdata = 32'h33; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++; if (s_axi_bvalid !== 1'b0) begin
        miscompares++; $display("FAIL aw_only_bvalid cycle=%0d got=%b exp=0", k, s_axi_bvalid);
      end
    end
    s_axi_awvalid = 1'b0;
    vectors++; if (gpio_out !== 8'hA5) begin
      miscompares++; $display("FAIL aw_only_no_write got=%h exp=a5", gpio_out); end
    axi_read(32'h1C, d, r, v);
    vectors++; if (d !== 32'h0 || r !== 2'b10) begin
      miscompares++; $display("FAIL read_1c got=%h/%b exp=0/10", d, r); end
    axi_read(32'h40, d, r, v);
    vectors++; if (d !== 32'h0 || r !== 2'b10) begin
      miscompares++; $display("FAIL read_40 got=%h/%b exp=0/10", d, r); end
    axi_write(32'h1C, 32'hFF, 4'hF, r, v);
    vectors++; if (r !== 2'b10) begin
      miscompares++; $display("FAIL write_1c_bresp got=%b exp=10", r); end
    axi_write(32'h00, 32'hFF, 4'hF, r, v);
    vectors++; if (r !== 2'b00) begin
      miscompares++; $display("FAIL write_datain_bresp got=%b exp=00", r); end
    // Stalled read: rdata must hold while rready stays low
    s_axi_araddr = 32'h04; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
    tick();
    s_axi_arvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vectors++; if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'hA5) begin
        miscompares++; $display("FAIL read_stall cycle=%0d got=%b/%h exp=1/000000a5",
                                k, s_axi_rvalid, s_axi_rdata); end
      tick();
    end
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    vectors++; if (s_axi_rvalid !== 1'b0) begin
      miscompares++; $display("FAIL read_release got=%b exp=0", s_axi_rvalid); end
    // Reset while the write response is pending
    s_axi_awaddr = 32'h04; s_axi_wdata = 32'h11; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    s_axi_bready = 1'b0;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    vectors++; if (s_axi_bvalid !== 1'b1) begin
      miscompares++; $display("FAIL wresp_pending got=%b exp=1", s_axi_bvalid); end
    rst_n = 1'b0;
    tick();
    vectors++; if (s_axi_bvalid !== 1'b0 || gpio_out !== 8'h00) begin
      miscompares++; $display("FAIL reset_in_wresp got=%b/%h exp=0/00", s_axi_bvalid, gpio_out);
    end
    rst_n = 1'b1;
    tick();
    vectors++; if (s_axi_awready !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_wresp_ready got=%b exp=1", s_axi_awready); end
  endtask

  task automatic test_random();
    logic [1:0] r; logic v; logic [31:0] d, a;
    int op;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) gpio_in = NP'($urandom);
      a = ($urandom_range(0, 9) == 0) ? 32'h40 : 32'($urandom_range(0, 7) * 4);
      op = $urandom_range(0, 2);
      if (op == 0) begin
        axi_write(a, $urandom, 4'($urandom), r, v);
        vectors++; if (r !== m_bresp) begin
          miscompares++; $display("FAIL rand_bresp n=%0d addr=%h got=%b exp=%b", n, a, r, m_bresp);
        end
      end else if (op == 1) begin
        axi_read(a, d, r, v);
        vectors++; if (d !== m_rdata || r !== m_rresp) begin
          miscompares++; $display("FAIL rand_read n=%0d addr=%h got=%h/%b exp=%h/%b",
                                  n, a, d, r, m_rdata, m_rresp); end
      end else begin
        tick();
      end
      vectors++; if (irq_o !== m_irq || gpio_out !== m_out || gpio_oe !== m_dir) begin
        miscompares++; $display("FAIL rand_outputs n=%0d got=%b/%h/%h exp=%b/%h/%h",
                                n, irq_o, gpio_out, gpio_oe, m_irq, m_out, m_dir); end
    end
  endtask

  initial begin
    rst_n = 1'b0; gpio_in = '0;
    s_axi_awaddr = '0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_araddr = '0;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    test_reset();
    test_rw();
    test_edge_irq();
    test_level_irq();
    test_collision();
    test_protocol();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
